// File: rtl/axis_master0.sv
// AXI4-Stream master: a byte FIFO of {last, data} drained through a single registered
// output beat, with a per-packet TDEST and packet/overflow status.
module axis_master0 #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 5,
  parameter int DEPTH  = 16
) (
  input  logic              i_mclk,
  input  logic              i_mrst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_last,
  output logic              o_wr_full,
  input  logic [DEST_W-1:0] i_tdest,
  input  logic              i_m_tready,
  output logic              o_m_tvalid,
  output logic [DATA_W-1:0] o_m_tdata,
  output logic [DEST_W-1:0] o_m_tdest,
  output logic              o_m_tlast,
  output logic              o_busy,
  output logic [15:0]       o_pkt_count,
  output logic              o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [DATA_W:0]   fifo_mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q;
  logic [DEST_W-1:0] dest_q;
  logic              tvalid_q, tlast_q;
  logic [DATA_W-1:0] tdata_q;
  logic [15:0]       pkt_cnt_q;
  logic              overflow_q;

  logic              fifo_empty, push, load, busy, beat_xfer, last_xfer;
  logic [DATA_W:0]   head;

  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];
  assign beat_xfer  = tvalid_q && i_m_tready;
  assign last_xfer  = beat_xfer && tlast_q;
  // A pop frees a slot in the same cycle, so a push while full is still accepted then.
  assign push       = i_wr_en && (!full_q || load);

  always_ff @(posedge i_mclk) begin
    if (i_mrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = SEND;
      SEND: if (last_xfer)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stop loading once a tlast beat sits in the stage; the packet ends with it.
  always_comb begin
    load = 1'b0;
    busy = 1'b0;
    case (state_q)
      SEND: begin
        busy = 1'b1;
        load = !fifo_empty && (!tvalid_q || i_m_tready) && !(tvalid_q && tlast_q);
      end
      default: begin
        load = 1'b0;
        busy = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_mclk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {i_wr_last, i_wr_data};
  end

  always_ff @(posedge i_mclk) begin
    if (i_mrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      if (i_wr_en && full_q && !load) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge i_mclk) begin
    if (i_mrst) begin
      dest_q    <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && !fifo_empty) dest_q <= i_tdest;
      if (load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= head[DATA_W-1:0];
        tlast_q  <= head[DATA_W];
      end else if (beat_xfer) begin
        tvalid_q <= 1'b0;
      end
      if (last_xfer) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign o_wr_full   = full_q;
  assign o_m_tvalid  = tvalid_q;
  assign o_m_tdata   = tdata_q;
  assign o_m_tdest   = dest_q;
  assign o_m_tlast   = tlast_q;
  assign o_busy      = busy;
  assign o_pkt_count = pkt_cnt_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_axis_master0.sv
// Bench for axis_master0: table-driven first packet, directed corner cases, then random traffic.
module tb_axis_master0;

  localparam int DATA_W = 8;
  localparam int DEST_W = 5;
  localparam int DEPTH  = 16;

  logic              i_mclk, i_mrst, i_wr_en, i_wr_last, i_m_tready;
  logic [DATA_W-1:0] i_wr_data;
  logic [DEST_W-1:0] i_tdest;
  logic              o_wr_full, o_m_tvalid, o_m_tlast, o_busy, o_overflow;
  logic [DATA_W-1:0] o_m_tdata;
  logic [DEST_W-1:0] o_m_tdest;
  logic [15:0]       o_pkt_count;

  axis_master0 #(.DATA_W(DATA_W), .DEST_W(DEST_W), .DEPTH(DEPTH)) dut (
    .i_mclk(i_mclk), .i_mrst(i_mrst),
    .i_wr_en(i_wr_en), .i_wr_data(i_wr_data), .i_wr_last(i_wr_last), .o_wr_full(o_wr_full),
    .i_tdest(i_tdest), .i_m_tready(i_m_tready),
    .o_m_tvalid(o_m_tvalid), .o_m_tdata(o_m_tdata), .o_m_tdest(o_m_tdest), .o_m_tlast(o_m_tlast),
    .o_busy(o_busy), .o_pkt_count(o_pkt_count), .o_overflow(o_overflow)
  );

  initial begin
    i_mclk = 1'b0;
    forever #5 i_mclk = ~i_mclk;
  end

  typedef struct packed {
    logic [7:0] data;
    logic [4:0] dest;
    logic       last;
  } beat_t;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       last;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  prev_stall = 1'b0;
  logic  prev_last_hs = 1'b0;
  beat_t prev_beat = '0;
  vec_t  vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe outputs on the falling edge, return just after the rising edge.
  task automatic tick();
    beat_t cur;
    logic  hs;
    @(negedge i_mclk);
    cur.data = o_m_tdata;
    cur.dest = o_m_tdest;
    cur.last = o_m_tlast;
    if (prev_stall) chk("hold_beat", {o_m_tvalid, cur}, {1'b1, prev_beat});
    if (prev_last_hs) chk("pkt_gap", {63'd0, o_m_tvalid}, 64'd0);
    hs = o_m_tvalid && i_m_tready && !i_mrst;
    if (hs) obs_q.push_back(cur);
    prev_stall   = o_m_tvalid && !i_m_tready && !i_mrst;
    prev_last_hs = hs && o_m_tlast;
    prev_beat    = cur;
    @(posedge i_mclk);
    #1;
  endtask

  task automatic do_reset();
    i_mrst  = 1'b1;
    i_wr_en = 1'b0;
    tick();
    chk("reset_outputs",
        {o_m_tvalid, o_m_tdata, o_m_tdest, o_m_tlast, o_busy, o_pkt_count, o_overflow, o_wr_full},
        64'd0);
    i_mrst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    i_wr_en   = 1'b1;
    i_wr_data = d;
    i_wr_last = l;
    tick();
    i_wr_en   = 1'b0;
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic [4:0] t, input logic l);
    beat_t b;
    b.data = d;
    b.dest = t;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic expect_beats(input string name);
    chk({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!o_m_tvalid && n < 20) begin
      tick();
      n++;
    end
    chk(name, {63'd0, o_m_tvalid}, 64'd1);
  endtask

  task automatic drain(input int n);
    i_m_tready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    int model_pkt;
    vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0};
    vecs[2] = '{1'b1, 8'hA3, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 16'd0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 16'd0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 16'd0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};

    i_mrst = 1'b1; i_wr_en = 1'b0; i_wr_data = '0; i_wr_last = 1'b0;
    i_tdest = '0; i_m_tready = 1'b0;
    do_reset();

    // Packet A1..A3, dest 1, always ready: checked cycle by cycle.
    i_tdest = 5'd1;
    i_m_tready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      i_wr_en   = vecs[k].wr;
      i_wr_data = vecs[k].data;
      i_wr_last = vecs[k].last;
      tick();
      if (vecs[k].e_valid)
        chk($sformatf("t1_row%0d", k),
            {o_m_tvalid, o_m_tdata, o_m_tlast, o_m_tdest, o_busy, o_pkt_count, o_wr_full},
            {1'b1, vecs[k].e_data, vecs[k].e_last, 5'd1, vecs[k].e_busy, vecs[k].e_cnt, 1'b0});
      else
        chk($sformatf("t1_row%0d", k), {o_m_tvalid, o_busy, o_pkt_count, o_wr_full},
            {1'b0, vecs[k].e_busy, vecs[k].e_cnt, 1'b0});
    end
    expect_beat(8'hA1, 5'd1, 1'b0);
    expect_beat(8'hA2, 5'd1, 1'b0);
    expect_beat(8'hA3, 5'd1, 1'b1);
    expect_beats("t1");

    // Same packet under a stall pattern.
    i_m_tready = 1'b0;
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    push(8'hA3, 1'b1);
    wait_valid("t2_valid");
    foreach (vecs[p]) if (p < 6) begin
      i_m_tready = (p == 0 || p == 3 || p == 5);
      tick();
    end
    i_m_tready = 1'b0;
    repeat (3) tick();
    expect_beat(8'hA1, 5'd1, 1'b0);
    expect_beat(8'hA2, 5'd1, 1'b0);
    expect_beat(8'hA3, 5'd1, 1'b1);
    expect_beats("t2");
    chk("t2_pkt_count", 64'(o_pkt_count), 64'd2);

    // Fill past capacity with no backpressure relief; the stage also holds one beat.
    do_reset();
    i_tdest = 5'd4;
    i_m_tready = 1'b0;
    for (int k = 1; k <= DEPTH + 2; k++) begin
      push(8'(8'h40 + k), k == DEPTH + 1);
      chk($sformatf("t3_full_after%0d", k), {63'd0, o_wr_full}, 64'(k >= DEPTH + 1));
      chk($sformatf("t3_ovf_after%0d", k), {63'd0, o_overflow}, 64'(k >= DEPTH + 2));
      if (k <= DEPTH + 1) expect_beat(8'(8'h40 + k), 5'd4, k == DEPTH + 1);
    end
    drain(DEPTH + 8);
    expect_beats("t3");
    chk("t3_ovf_sticky", {62'd0, o_overflow, o_wr_full}, 64'd2);

    // Two queued packets, dest changed mid-packet.
    do_reset();
    i_tdest = 5'd2;
    i_m_tready = 1'b1;
    push(8'd10, 1'b0);
    push(8'd11, 1'b1);
    i_tdest = 5'd7;
    push(8'd20, 1'b1);
    drain(10);
    expect_beat(8'd10, 5'd2, 1'b0);
    expect_beat(8'd11, 5'd2, 1'b1);
    expect_beat(8'd20, 5'd7, 1'b1);
    expect_beats("t4");
    chk("t4_pkt_count", 64'(o_pkt_count), 64'd2);

    // Underrun mid-packet.
    i_tdest = 5'd3;
    push(8'd50, 1'b0);
    repeat (5) tick();
    chk("t5_underrun", {62'd0, o_m_tvalid, o_busy}, 64'd1);
    push(8'd51, 1'b1);
    drain(8);
    expect_beat(8'd50, 5'd3, 1'b0);
    expect_beat(8'd51, 5'd3, 1'b1);
    expect_beats("t5");
    chk("t5_pkt_count", 64'(o_pkt_count), 64'd3);

    // Reset while a beat is stalled.
    i_tdest = 5'd6;
    i_m_tready = 1'b0;
    push(8'd60, 1'b0);
    push(8'd61, 1'b1);
    wait_valid("t6_valid");
    do_reset();
    repeat (4) tick();
    chk("t6_flushed", {62'd0, o_m_tvalid, o_busy}, 64'd0);
    obs_q.delete();
    i_tdest = 5'd9;
    i_m_tready = 1'b1;
    push(8'd70, 1'b1);
    drain(8);
    expect_beat(8'd70, 5'd9, 1'b1);
    expect_beats("t6");
    chk("t6_pkt_count", 64'(o_pkt_count), 64'd1);

    // Random traffic against a queue model.
    do_reset();
    model_pkt = 0;
    for (int r = 0; r < 8; r++) begin
      int pushed, cyc, nbytes, rdy_pct;
      logic [4:0] dest;
      logic [7:0] d;
      logic l;
      dest    = 5'($urandom_range(0, 31));
      rdy_pct = int'($urandom_range(20, 100));
      nbytes  = int'($urandom_range(5, 40));
      i_tdest = dest;
      pushed  = 0;
      cyc     = 0;
      while ((pushed < nbytes || obs_q.size() < exp_q.size()) && cyc < 3000) begin
        if (pushed < nbytes && $urandom_range(0, 1) == 1 && (pushed - obs_q.size()) < DEPTH) begin
          d = 8'($urandom);
          l = (pushed == nbytes - 1) || ($urandom_range(0, 3) == 0);
          i_wr_en   = 1'b1;
          i_wr_data = d;
          i_wr_last = l;
          expect_beat(d, dest, l);
          if (l) model_pkt++;
          pushed++;
        end else begin
          i_wr_en = 1'b0;
        end
        i_m_tready = (pushed == nbytes) ? 1'b1 : (int'($urandom_range(1, 100)) <= rdy_pct);
        tick();
        cyc++;
      end
      i_wr_en = 1'b0;
      expect_beats($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_ovf", r), {63'd0, o_overflow}, 64'd0);
      chk($sformatf("rnd%0d_pkt_count", r), 64'(o_pkt_count), 64'(16'(model_pkt)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
